rs_button_sequencer: RTL and testbench
======================================

Name: rs_button_sequencer

Overview:
- Upstream stage for the RS flip-flop. Turns two raw, bouncing push-button inputs into clean, mutually exclusive, fixed-width S and R pulses on the RS flip-flop's clock domain.
- Each button is synchronised, then debounced by a per-channel FSM.
- A small arbiter guarantees S and R are never high together, inserts a gap between pulses, and flags simultaneous requests.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchroniser samples required to accept a press or release. Legal range is 2 or more.
- PULSE_LEN, 2: width of each S/R output pulse, in clock cycles. Legal range is 1 or more.
- CNT_W, 3: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- Clk  in  1  system clock; all state updates on its rising edge
- Reset  in  1  synchronous, active-high reset
- E  in  1  enable; when 0, new press requests are discarded
- Set_Btn  in  1  raw asynchronous set button
- Reset_Btn  in  1  raw asynchronous reset button
- S  out  1  registered set pulse to RS flip-flop
- R  out  1  registered reset pulse to RS flip-flop
- Busy  out  1  high while an S or R pulse is in progress
- Conflict  out  1  one-cycle flag: simultaneous set/reset requests were dropped

Behaviour:
- Reset (sampled high on any edge) clears all state. The next cycle shows S=0, R=0, Busy=0, Conflict=0, both FSMs in IDLE, counters=0, pending bits=0. Reset mid-pulse truncates the pulse immediately.
- Synchroniser: two flops per button; sync2 is the FSM input. A change sampled at edge k is visible to the FSM at edge k+2.
- Channel FSM states and transitions:
  - IDLE: sync2=1 -> PRESS_WAIT, cnt=1.
  - PRESS_WAIT: sync2=0 -> IDLE, cnt=0. Otherwise cnt+1. When the incremented value equals DEBOUNCE_CYCLES -> HELD and assert req for one cycle.
  - HELD: sync2=0 -> RELEASE_WAIT, cnt=1. No further req while held; no auto-repeat.
  - RELEASE_WAIT: sync2=1 -> HELD, cnt=0. cnt reaching DEBOUNCE_CYCLES -> IDLE.
  - A bounce (one-sample glitch) in either WAIT state restarts from the prior stable state.
- Timing: raw high sampled at edge k gives a channel req during the cycle after edge k+1+DEBOUNCE_CYCLES. The output pulse is high during the PULSE_LEN cycles following edge k+2+DEBOUNCE_CYCLES.
- E gating: a req arriving while E=0 is discarded, not pended. The FSMs keep tracking regardless of E.
- Arbiter, idle (Busy=0):
  - Exactly one req or pending bit -> start that pulse next edge and clear its pending bit.
  - Both req (or both pending) -> neither fires, both pending bits cleared, Conflict=1 for one cycle.
- Arbiter, busy:
  - An incoming req sets that channel's pending bit. A repeat of the same channel is absorbed.
  - If both pending bits end up set, both are cleared and Conflict pulses.
- Pulse end: after PULSE_LEN cycles the output drops, and Busy drops in the same cycle.
- A pending pulse starts on the edge after Busy=0 is observed, giving at least 1 low cycle between consecutive pulses.
- Invariants: S and R are never both 1. Busy is exactly S|R.

Decomposition:
- Shared include/package holds:
  - channel FSM state encodings (IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3);
  - default DEBOUNCE_CYCLES/PULSE_LEN constants.
- One sub-module, btn_debounce: synchroniser, channel FSM and counter, outputting the one-cycle req. It is instantiated twice.
- The arbiter, pulse counter and pending bits live in rs_button_sequencer.

Test Plan:
- Clean press: Reset 2 cycles, E=1, Set_Btn 0->1 sampled edge 10, held 20 cycles -> S=1 exactly during cycles after edges 16 and 17 (D=4, PULSE_LEN=2). R=0 throughout; Busy mirrors S.
- Bounce rejection: Set_Btn toggles 1,0,1,0 on successive edges, then stays 1 -> single S pulse, DEBOUNCE_CYCLES+2 cycles after the last rising sample. No pulse from the glitches.
- Simultaneous press: both buttons rise on the same edge -> S=R=0 throughout, Conflict=1 for exactly one cycle, Busy stays 0.
- Overlap: Reset_Btn req arrives during S pulse -> R pulse of 2 cycles starts after 1 low gap cycle. S and R are never high together.
- Enable gating: E=0 during a Set_Btn press -> no S pulse. Raising E while the button is still held produces no pulse; the next release/press with E=1 produces one.
- Reset mid-operation: Reset during the first S pulse cycle -> S=0 and Busy=0 the next cycle. A held button, once released and re-pressed after reset, produces a normal pulse.

Source files
------------

// File: rtl/rs_button_sequencer_pkg.sv
// Shared types and defaults for the push-button to RS-pulse front end.
package rs_button_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_PULSE_LEN       = 2;
    localparam int DEF_CNT_W           = 3;

endpackage

// File: rtl/rs_button_sequencer_btn_debounce.sv
// One button channel: two-flop synchroniser, debounce FSM, one-cycle press req.
module btn_debounce
    import rs_button_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic req
);

    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync2_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             req_q, req_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = 1'b0;
        cnt_inc = cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_DONE) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_DONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    assign req = req_q;

endmodule

// File: rtl/rs_button_sequencer.sv
// Two debounced buttons arbitrated into exclusive, fixed-width S/R pulses
// with a mandatory low gap and a conflict flag for simultaneous requests.
module rs_button_sequencer
    import rs_button_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_LEN       = DEF_PULSE_LEN,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic Clk,
    input  logic Reset,
    input  logic E,
    input  logic Set_Btn,
    input  logic Reset_Btn,
    output logic S,
    output logic R,
    output logic Busy,
    output logic Conflict
);

    localparam int PCNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_LEN - 1);

    logic req_set, req_rst;
    logic want_s, want_r, busy;

    logic              s_q, s_d;
    logic              r_q, r_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              pend_s_q, pend_s_d;
    logic              pend_r_q, pend_r_d;
    logic              conflict_q, conflict_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_set_ch (
        .clk    (Clk),
        .rst    (Reset),
        .btn_raw(Set_Btn),
        .req    (req_set)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_rst_ch (
        .clk    (Clk),
        .rst    (Reset),
        .btn_raw(Reset_Btn),
        .req    (req_rst)
    );

    // Disabled requests are dropped here; they never reach the pending bits.
    assign want_s = pend_s_q | (req_set & E);
    assign want_r = pend_r_q | (req_rst & E);
    assign busy   = s_q | r_q;

    always_comb begin
        s_d        = s_q;
        r_d        = r_q;
        pcnt_d     = pcnt_q;
        pend_s_d   = pend_s_q;
        pend_r_d   = pend_r_q;
        conflict_d = 1'b0;
        if (busy) begin
            if (pcnt_q == PCNT_LAST) begin
                s_d    = 1'b0;
                r_d    = 1'b0;
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
            if (want_s && want_r) begin
                pend_s_d   = 1'b0;
                pend_r_d   = 1'b0;
                conflict_d = 1'b1;
            end else begin
                pend_s_d = want_s;
                pend_r_d = want_r;
            end
        end else begin
            pend_s_d = 1'b0;
            pend_r_d = 1'b0;
            pcnt_d   = '0;
            if (want_s && want_r) begin
                conflict_d = 1'b1;
            end else if (want_s) begin
                s_d = 1'b1;
            end else if (want_r) begin
                r_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            pcnt_q     <= '0;
            pend_s_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            pcnt_q     <= pcnt_d;
            pend_s_q   <= pend_s_d;
            pend_r_q   <= pend_r_d;
            conflict_q <= conflict_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign Busy     = busy;
    assign Conflict = conflict_q;

endmodule

// File: tb/tb_rs_button_sequencer.sv
// Randomised scoreboard bench for rs_button_sequencer against a level/run-length model.
module tb_rs_button_sequencer;

    localparam int D  = 4;
    localparam int PL = 2;

    logic Clk = 1'b0;
    logic Reset, E, Set_Btn, Reset_Btn;
    logic S, R, Busy, Conflict;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [3:0] exp_q[$];
    logic [3:0] ev;

    // model state: raw delay line, stable level, run length of disagreeing samples
    int m_d1[2], m_d2[2], m_stable[2], m_run[2];
    bit m_req[2], m_pend[2];
    int m_left, m_who;
    bit m_conf;

    always #5 Clk = ~Clk;

    rs_button_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .PULSE_LEN      (PL),
        .CNT_W          (3)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .E        (E),
        .Set_Btn  (Set_Btn),
        .Reset_Btn(Reset_Btn),
        .S        (S),
        .R        (R),
        .Busy     (Busy),
        .Conflict (Conflict)
    );

    task automatic model_step();
        bit want[2];
        int btn[2];
        int lvl;
        logic es, er, eb;
        btn[0] = int'(Set_Btn);
        btn[1] = int'(Reset_Btn);
        if (Reset) begin
            for (int c = 0; c < 2; c++) begin
                m_d1[c] = 0; m_d2[c] = 0; m_stable[c] = 0;
                m_run[c] = 0; m_req[c] = 0; m_pend[c] = 0;
            end
            m_left = 0; m_who = 0; m_conf = 0;
        end else begin
            for (int c = 0; c < 2; c++)
                want[c] = m_pend[c] | (m_req[c] & E);
            m_conf = 0;
            if (m_left > 0) begin
                m_left--;
                if (want[0] && want[1]) begin
                    m_pend[0] = 0; m_pend[1] = 0; m_conf = 1;
                end else begin
                    m_pend[0] = want[0]; m_pend[1] = want[1];
                end
            end else begin
                m_pend[0] = 0; m_pend[1] = 0;
                if (want[0] && want[1]) m_conf = 1;
                else if (want[0]) begin m_left = PL; m_who = 0; end
                else if (want[1]) begin m_left = PL; m_who = 1; end
            end
            for (int c = 0; c < 2; c++) begin
                lvl = m_d2[c];
                m_req[c] = 0;
                if (lvl != m_stable[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_stable[c] = lvl;
                        m_run[c] = 0;
                        m_req[c] = (lvl == 1);
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_d2[c] = m_d1[c];
                m_d1[c] = btn[c];
            end
        end
        es = (m_left > 0) && (m_who == 0);
        er = (m_left > 0) && (m_who == 1);
        eb = (m_left > 0);
        exp_q.push_back({es, er, eb, logic'(m_conf)});
    endtask

    task automatic tick(input bit sb, input bit rb, input bit en, input bit rst);
        Set_Btn   = sb;
        Reset_Btn = rb;
        E         = en;
        Reset     = rst;
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic hold(input bit sb, input bit rb, input bit en, input int n);
        for (int i = 0; i < n; i++) tick(sb, rb, en, 1'b0);
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                checks++;
                if ({S, R, Busy, Conflict} !== ev) begin
                    errors++;
                    $display("FAIL outputs t=%0t SRBC got %b want %b", $time,
                             {S, R, Busy, Conflict}, ev);
                end
                checks++;
                if ((S & R) || (Busy !== (S | R))) begin
                    errors++;
                    $display("FAIL invariant t=%0t S=%b R=%b Busy=%b want exclusive and Busy=S|R",
                             $time, S, R, Busy);
                end
                if (ev[3] || ev[2]) pulses++;
            end
        end
    end

    initial begin
        int dur;
        bit sb, rb, en;
        Set_Btn = 0; Reset_Btn = 0; E = 1; Reset = 1;
        tick(0, 0, 1, 1);
        tick(0, 0, 1, 1);
        hold(0, 0, 1, 7);
        // clean press
        hold(1, 0, 1, 20);
        hold(0, 0, 1, 15);
        // bounce then settle
        tick(1, 0, 1, 0); tick(0, 0, 1, 0);
        tick(1, 0, 1, 0); tick(0, 0, 1, 0);
        hold(1, 0, 1, 15);
        hold(0, 0, 1, 15);
        // simultaneous press
        hold(1, 1, 1, 15);
        hold(0, 0, 1, 15);
        // overlapping requests
        tick(1, 0, 1, 0);
        hold(1, 1, 1, 20);
        hold(0, 0, 1, 15);
        // enable gating
        hold(1, 0, 0, 15);
        hold(1, 0, 1, 10);
        hold(0, 0, 1, 15);
        hold(1, 0, 1, 15);
        hold(0, 0, 1, 15);
        // reset during first pulse cycle
        hold(1, 0, 1, 7);
        tick(1, 0, 1, 1);
        hold(1, 0, 1, 10);
        hold(0, 0, 1, 15);
        hold(1, 0, 1, 15);
        hold(0, 0, 1, 15);
        // random segments
        for (int s = 0; s < 300; s++) begin
            dur = $urandom_range(1, 14);
            sb  = ($urandom_range(0, 2) == 0);
            rb  = ($urandom_range(0, 2) == 0);
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 99) == 0) tick(sb, rb, en, 1'b1);
            hold(sb, rb, en, dur);
        end
        hold(0, 0, 1, 20);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        checks++;
        if (pulses == 0) begin
            errors++;
            $display("FAIL activity: model produced %0d pulse cycles, want >0", pulses);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
